// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcodes, request payload and opcode helpers.
package alu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SHAMT_W = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } alu_req_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic has_arith_flags(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the ALU arbiter.
interface alu_share_arbiter_if;
  import alu_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_opcode;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_opcode;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_overflow;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output req_valid, req0_a, req0_b, req0_opcode, req1_a, req1_b, req1_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_opcode, req1_a, req1_b, req1_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_64_bit.sv
// Combinational 64-bit ALU; carry/overflow only meaningful for ADD/SUB (SUB carry = borrow).
module alu_64_bit
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_opcode,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_overflow,
  output logic              o_zero
);

  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [SHAMT_W-1:0]  w_shamt;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
  assign w_shamt = i_b[SHAMT_W-1:0];

  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        o_result   = w_sum[DATA_W-1:0];
        o_carry    = w_sum[DATA_W];
        o_overflow = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_SUB: begin
        o_result   = w_diff[DATA_W-1:0];
        o_carry    = w_diff[DATA_W];
        o_overflow = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_SLL:  o_result = i_a << w_shamt;
      OP_SRL:  o_result = i_a >> w_shamt;
      OP_SRA:  o_result = $signed(i_a) >>> w_shamt;
      OP_SLT:  o_result = DATA_W'($signed(i_a) < $signed(i_b));
      OP_SLTU: o_result = DATA_W'(i_a < i_b);
      OP_XOR:  o_result = i_a ^ i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_AND:  o_result = i_a & i_b;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu_64_bit between two requesters with a one-entry response register.
// Optional illegal-opcode flagging is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  arb_state_t        r_state, w_state_nxt;
  logic              r_prio, w_prio_nxt;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_carry, r_rsp_overflow, r_rsp_zero, r_rsp_err;

  logic              w_slot_free, w_both, w_gnt_idx, w_accept, w_illegal;
  alu_req_t          w_req;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry, w_alu_overflow, w_alu_zero;

  // Grant: contention resolved by prio, a lone requester always wins
  assign w_slot_free = (r_state == ST_EMPTY) | bus.rsp_ready;
  assign w_both      = &bus.req_valid;
  assign w_gnt_idx   = w_both ? r_prio : bus.req_valid[1];
  assign w_accept    = rst_n & w_slot_free & (|bus.req_valid);
  assign bus.req_ready = w_accept ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  assign w_req = w_gnt_idx ? '{opcode: bus.req1_opcode, b: bus.req1_b, a: bus.req1_a}
                           : '{opcode: bus.req0_opcode, b: bus.req0_b, a: bus.req0_a};

  alu_64_bit u_alu (
    .i_a        (w_req.a),
    .i_b        (w_req.b),
    .i_opcode   (w_req.opcode),
    .o_result   (w_alu_result),
    .o_carry    (w_alu_carry),
    .o_overflow (w_alu_overflow),
    .o_zero     (w_alu_zero)
  );

`ifdef ALU_ARB_OPCHECK_EN
  assign w_illegal = !is_legal_op(w_req.opcode);
`else
  assign w_illegal = 1'b0;
`endif

  // Next state / priority
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
    if (w_accept && w_both) w_prio_nxt = ~w_gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_EMPTY;
      r_prio         <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_carry    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      if (w_accept) begin
        r_rsp_id       <= w_gnt_idx;
        r_rsp_result   <= w_illegal ? '0 : w_alu_result;
        r_rsp_carry    <= !w_illegal && has_arith_flags(w_req.opcode) && w_alu_carry;
        r_rsp_overflow <= !w_illegal && has_arith_flags(w_req.opcode) && w_alu_overflow;
        r_rsp_zero     <= w_illegal | w_alu_zero;
        r_rsp_err      <= w_illegal;
      end
    end
  end

  assign bus.rsp_valid    = (r_state == ST_FULL);
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_carry    = r_rsp_carry;
  assign bus.rsp_overflow = r_rsp_overflow;
  assign bus.rsp_zero     = r_rsp_zero;
  assign bus.rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter; honours ALU_ARB_OPCHECK_EN for the illegal-opcode case.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  alu_share_arbiter_if bus ();

  alu_share_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [63:0] res,
                           input logic c, input logic o, input logic z);
    check_eq({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    check_eq({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
    check_eq({tag, "_result"}, bus.rsp_result, res);
    check_eq({tag, "_cvz"}, {61'd0, bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero}, {61'd0, c, o, z});
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_opcode = OP_ADD;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_opcode = OP_ADD;
    bus.rsp_ready = 1'b0;

    // Reset values, req_ready held low while in reset
    step(); step();
    check_eq("rst_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_id", 64'(bus.rsp_id), 64'd0);
    check_eq("rst_result", bus.rsp_result, 64'd0);
    check_eq("rst_flags", {60'd0, bus.rsp_carry, bus.rsp_overflow, bus.rsp_zero, bus.rsp_err}, 64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);

    // 1: port 0 ADD overflow
    rst_n = 1'b1;
    bus.req_valid = 2'b01;
    bus.req0_a = 64'h7FFF_FFFF_FFFF_FFFF; bus.req0_b = 64'd1; bus.req0_opcode = OP_ADD;
    bus.rsp_ready = 1'b1;
    #1 check_eq("t1_req_ready", 64'(bus.req_ready), 64'd1);
    step();
    check_rsp("t1", 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    // 2: contention alternates 0,1,0,1
    bus.req_valid = 2'b11;
    bus.req0_a = 64'd1; bus.req0_b = 64'd2; bus.req0_opcode = OP_ADD;
    bus.req1_a = 64'd0; bus.req1_b = 64'd1; bus.req1_opcode = OP_SUB;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("t2_req_ready", 64'(bus.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      step();
      if (i % 2 == 0) check_rsp("t2_p0", 1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
      else            check_rsp("t2_p1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    end

    // 3: SRA held under backpressure, then drain + accept in one cycle
    bus.req_valid = 2'b01;
    bus.req0_a = 64'h8000_0000_0000_0000; bus.req0_b = 64'd32; bus.req0_opcode = OP_SRA;
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b10;
    bus.req1_a = 64'h5555_5555_5555_5555; bus.req1_b = 64'hAAAA_AAAA_AAAA_AAAA; bus.req1_opcode = OP_XOR;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("t3_stall_ready", 64'(bus.req_ready), 64'd0);
      check_rsp("t3_hold", 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1 check_eq("t3_drain_ready", 64'(bus.req_ready), 64'd2);
    step();

    // 4: XOR then SLTU from port 1
    check_rsp("t4_xor", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    bus.req1_a = 64'h7FFF_FFFF_FFFF_FFFF; bus.req1_b = 64'h8000_0000_0000_0000; bus.req1_opcode = OP_SLTU;
    step();
    check_rsp("t4_sltu", 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b00;
    step();
    check_eq("t4_drain_empty", 64'(bus.rsp_valid), 64'd0);

    // 5: flip prio to 1, then reset while FULL
    bus.req_valid = 2'b11;
    bus.req0_a = 64'd0; bus.req0_b = 64'd0; bus.req0_opcode = OP_ADD;
    step();
    check_rsp("t5_zero", 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    step();
    check_eq("t5_rst_valid", 64'(bus.rsp_valid), 64'd0);
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    #1 check_eq("t5_prio_reset", 64'(bus.req_ready), 64'd1);
    step();
    check_eq("t5_post_rst_id", 64'(bus.rsp_id), 64'd0);

    // 6: illegal opcode
    bus.req_valid = 2'b01;
    bus.req0_a = 64'd5; bus.req0_b = 64'd3; bus.req0_opcode = 4'b1111;
    step();
    check_eq("t6_valid", 64'(bus.rsp_valid), 64'd1);
`ifdef ALU_ARB_OPCHECK_EN
    check_eq("t6_err", 64'(bus.rsp_err), 64'd1);
    check_eq("t6_result", bus.rsp_result, 64'd0);
    check_eq("t6_zero", 64'(bus.rsp_zero), 64'd1);
`else
    check_eq("t6_err", 64'(bus.rsp_err), 64'd0);
`endif
    bus.req_valid = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
